rns2bin_seq_ctrl: RTL and testbench
===================================

Name: rns2bin_seq_ctrl

Overview:
- Sequencing controller plus time-multiplexed CRT datapath for RNS-to-binary conversion.
- Accepts a one-time moduli/inverse configuration, then precomputes M and every Q_i = M/m_i as a product of the other moduli.
- Converts residue tuples one modulus per cycle, with modular accumulation and signed output correction.
- Sits between the RNS arithmetic core and the binary output stage; valid/ready on both sides.

Parameters:
- MOD_NUM, 4, number of moduli.
- MOD_W, 4, width of each modulus, inverse and residue field.
- RANGE, MOD_NUM*MOD_W, width of M, Q_i, the accumulator and the signed output.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cfg_valid  input  1  configuration offered.
- cfg_ready  output  1  configuration can be accepted.
- cfg_mods  input  MOD_NUM*MOD_W  packed moduli; m_i at [i*MOD_W +: MOD_W].
- cfg_invs  input  MOD_NUM*MOD_W  packed inverses A_i = Q_i^-1 mod m_i, same packing.
- cfg_done  output  1  configuration valid and M/Q table ready.
- cfg_err  output  1  last configuration rejected.
- in_valid  input  1  residue tuple offered.
- in_ready  output  1  tuple can be accepted.
- in_res  input  MOD_NUM*MOD_W  packed residues c_i.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_x  output  RANGE  signed (two's complement) result.
- out_m  output  RANGE  current dynamic range M, for downstream.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE; cfg_done=0, cfg_err=0, out_valid=0, out_x=0, out_m=0; M and Q table cleared.
- Reset mid-operation: aborts any CFG/ACC/output; configuration is lost.
- States: IDLE, CFG_M, CFG_Q, ACC, SIGN, OUT.
- cfg_ready = (state==IDLE). in_ready = (state==IDLE) && cfg_done && !cfg_valid. If both are valid in IDLE, configuration wins.
- Configuration accept: latch moduli and inverses; clear cfg_done and cfg_err.
  - If any m_i < 2: set cfg_err=1, stay in IDLE, cfg_done stays 0.
  - Otherwise go to CFG_M.
- CFG_M: MOD_NUM cycles, one multiply per cycle, M starts at 1 and M = M*m_k for k=0..MOD_NUM-1.
- CFG_Q: MOD_NUM*MOD_NUM cycles; index (i,j) with j inner, Q_i starts at 1, Q_i = Q_i*(j==i ? 1 : m_j).
  - After the last step: cfg_done=1, out_m=M, return to IDLE.
  - Configuration latency is MOD_NUM+MOD_NUM^2 cycles from the accept edge (20 at defaults).
- Input accept: latch in_res, acc=0, k=0, go to ACC.
- ACC: one cycle per modulus k.
  - t = (c_k*A_k) mod m_k, computed combinationally at 2*MOD_W by MOD_W bits.
  - s = acc + t*Q_k; acc = (s >= M) ? s-M : s. Since t*Q_k < M, one conditional subtraction suffices.
  - Residues >= m_k are thereby used modulo m_k; no error is flagged.
  - After k = MOD_NUM-1, go to SIGN.
- SIGN: H = (M+1)>>1. out_x = (acc >= H) ? acc-M : acc. Set out_valid=1 and go to OUT.
  - Representable range is [-floor(M/2), ceil(M/2)-1].
- OUT: hold out_x and out_valid stable until out_ready. On out_valid && out_ready, clear out_valid next edge and return to IDLE.
- Latency: out_valid rises MOD_NUM+1 edges after the input-accept edge. Throughput is one tuple per MOD_NUM+3 cycles with out_ready held high.
- Coprimality and inverse correctness are not checked. Wrong inverses produce a deterministic but wrong result.
- A new configuration is accepted only in IDLE, so it can never corrupt a conversion in progress.

Test Plan:
- Configure moduli {3,4,5,7}, inverses {2,1,4,2} -> cfg_done rises 20 cycles after accept; out_m=420; internal Q={140,105,84,60}; cfg_err=0.
- Residues {1,0,0,2} -> out_x=+100, 5 cycles after accept; residues {0,0,0,6} -> out_x=-120.
- Boundary: residues {2,1,4,6} -> +209; residues {0,2,0,0} -> -210; residues {0,0,0,0} -> 0.
- Backpressure: hold out_ready=0 for 10 cycles -> out_x/out_valid stable, in_ready=0; release -> IDLE the next cycle; the next tuple is accepted.
- Configure a modulus of 1 -> cfg_err=1, cfg_done=0, in_ready stays 0. Also drive in_valid before any configuration -> never accepted.
- Assert reset during ACC, then reconfigure and convert {1,0,0,2} -> no stale out_valid after reset; result is +100.

Source files
------------

// File: rtl/rns2bin_seq_ctrl.sv
// rns2bin_seq_ctrl
// Sequencing controller and time-multiplexed CRT datapath that turns RNS
// residue tuples into signed binary.
//
// A configuration (moduli m_i and inverses A_i = Q_i^-1 mod m_i) is loaded
// once. The block then precomputes M = prod(m_i) and every Q_i = M/m_i as a
// product of the other moduli, one multiply per cycle. Each tuple is then
// reduced one modulus per cycle, and the result is corrected into the signed
// range [-floor(M/2), ceil(M/2)-1].
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cfg_valid/ready   configuration handshake; cfg_mods/cfg_invs packed
//                     MOD_W fields, field i at [i*MOD_W +: MOD_W]
//   cfg_done          M/Q table is valid for the current configuration
//   cfg_err           last configuration had a modulus below 2
//   in_valid/ready    residue tuple handshake; in_res packed like cfg_mods
//   out_valid/ready   result handshake; out_x signed result
//   out_m             dynamic range M of the active configuration
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Once out_valid is high, out_x stays stable until that transfer. The
// ready outputs are decoded from the state only and never depend on the
// valid inputs of the same channel. When cfg_valid and in_valid are both
// high in IDLE, the configuration is taken and in_ready stays low.
module rns2bin_seq_ctrl #(
  parameter int MOD_NUM = 4,
  parameter int MOD_W   = 4,
  parameter int RANGE   = MOD_NUM * MOD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [MOD_NUM*MOD_W-1:0] cfg_mods,
  input  logic [MOD_NUM*MOD_W-1:0] cfg_invs,
  output logic                     cfg_done,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MOD_NUM*MOD_W-1:0] in_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RANGE-1:0]         out_x,
  output logic [RANGE-1:0]         out_m
);

  localparam int IDX_W = (MOD_NUM > 1) ? $clog2(MOD_NUM) : 1;
  localparam int PK_W  = MOD_NUM * MOD_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MOD_NUM - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG_M = 3'd1,
    CFG_Q = 3'd2,
    ACC   = 3'd3,
    SIGN  = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PK_W-1:0]   mods_q, mods_d;
  logic [PK_W-1:0]   invs_q, invs_d;
  logic [PK_W-1:0]   res_q, res_d;
  logic [RANGE-1:0]  m_q, m_d;
  logic [RANGE-1:0]  q_tab_q [MOD_NUM];
  logic [RANGE-1:0]  q_tab_d [MOD_NUM];
  logic [RANGE-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_i_q, idx_i_d;
  logic [IDX_W-1:0]  idx_j_q, idx_j_d;
  logic              cfg_done_q, cfg_done_d;
  logic              cfg_err_q, cfg_err_d;
  logic              out_valid_q, out_valid_d;
  logic [RANGE-1:0]  out_x_q, out_x_d;
  logic [RANGE-1:0]  out_m_q, out_m_d;

  // Datapath operands selected by the sequencing indices
  logic              cfg_bad;
  logic [MOD_W-1:0]  m_i, m_j, a_i, c_i;
  logic [RANGE-1:0]  q_i, q_mult, q_prod;
  logic [2*MOD_W-1:0] ca, ca_div, t_wide;
  logic [MOD_W-1:0]  t;
  logic [RANGE-1:0]  tq;
  logic [RANGE:0]    s, h;

  assign cfg_ready = (state_q == IDLE);
  assign in_ready  = (state_q == IDLE) && cfg_done_q && !cfg_valid;
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_m     = out_m_q;

  always_comb begin
    cfg_bad = 1'b0;
    for (int n = 0; n < MOD_NUM; n++) begin
      if (cfg_mods[n*MOD_W +: MOD_W] < MOD_W'(2)) cfg_bad = 1'b1;
    end

    // Constant-base selects keep the muxes explicit for every index value
    m_i = '0; m_j = '0; a_i = '0; c_i = '0; q_i = '0;
    for (int n = 0; n < MOD_NUM; n++) begin
      if (idx_i_q == IDX_W'(n)) begin
        m_i = mods_q[n*MOD_W +: MOD_W];
        a_i = invs_q[n*MOD_W +: MOD_W];
        c_i = res_q[n*MOD_W +: MOD_W];
        q_i = q_tab_q[n];
      end
      if (idx_j_q == IDX_W'(n)) m_j = mods_q[n*MOD_W +: MOD_W];
    end

    // Q_i skips its own modulus
    q_mult = (idx_i_q == idx_j_q) ? RANGE'(1) : RANGE'(m_j);
    q_prod = q_i * q_mult;

    // t = (c_k * A_k) mod m_k; the divisor guard only matters outside ACC
    ca     = (2*MOD_W)'(c_i) * (2*MOD_W)'(a_i);
    ca_div = (m_i == '0) ? (2*MOD_W)'(1) : (2*MOD_W)'(m_i);
    t_wide = ca % ca_div;
    t      = t_wide[MOD_W-1:0];

    // t*Q_k < M and acc < M, so s < 2M needs one extra bit and one subtract
    tq = RANGE'(t) * q_i;
    s  = {1'b0, acc_q} + {1'b0, tq};
    h  = ({1'b0, m_q} + (RANGE+1)'(1)) >> 1;

    state_d     = state_q;
    mods_d      = mods_q;
    invs_d      = invs_q;
    res_d       = res_q;
    m_d         = m_q;
    q_tab_d     = q_tab_q;
    acc_d       = acc_q;
    idx_i_d     = idx_i_q;
    idx_j_d     = idx_j_q;
    cfg_done_d  = cfg_done_q;
    cfg_err_d   = cfg_err_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_m_d     = out_m_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          mods_d     = cfg_mods;
          invs_d     = cfg_invs;
          cfg_done_d = 1'b0;
          cfg_err_d  = cfg_bad;
          if (!cfg_bad) begin
            m_d     = RANGE'(1);
            idx_i_d = '0;
            idx_j_d = '0;
            for (int n = 0; n < MOD_NUM; n++) q_tab_d[n] = RANGE'(1);
            state_d = CFG_M;
          end
        end else if (in_valid && cfg_done_q) begin
          res_d   = in_res;
          acc_d   = '0;
          idx_i_d = '0;
          state_d = ACC;
        end
      end
      CFG_M: begin
        m_d = m_q * RANGE'(m_i);
        if (idx_i_q == IDX_LAST) begin
          idx_i_d = '0;
          idx_j_d = '0;
          state_d = CFG_Q;
        end else begin
          idx_i_d = idx_i_q + IDX_W'(1);
        end
      end
      CFG_Q: begin
        for (int n = 0; n < MOD_NUM; n++) begin
          if (idx_i_q == IDX_W'(n)) q_tab_d[n] = q_prod;
        end
        if (idx_j_q == IDX_LAST) begin
          idx_j_d = '0;
          if (idx_i_q == IDX_LAST) begin
            cfg_done_d = 1'b1;
            out_m_d    = m_q;
            state_d    = IDLE;
          end else begin
            idx_i_d = idx_i_q + IDX_W'(1);
          end
        end else begin
          idx_j_d = idx_j_q + IDX_W'(1);
        end
      end
      ACC: begin
        acc_d = (s >= {1'b0, m_q}) ? RANGE'(s - {1'b0, m_q}) : s[RANGE-1:0];
        if (idx_i_q == IDX_LAST) begin
          state_d = SIGN;
        end else begin
          idx_i_d = idx_i_q + IDX_W'(1);
        end
      end
      SIGN: begin
        out_x_d     = ({1'b0, acc_q} >= h) ? (acc_q - m_q) : acc_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mods_q      <= '0;
      invs_q      <= '0;
      res_q       <= '0;
      m_q         <= '0;
      for (int n = 0; n < MOD_NUM; n++) q_tab_q[n] <= '0;
      acc_q       <= '0;
      idx_i_q     <= '0;
      idx_j_q     <= '0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_m_q     <= '0;
    end else begin
      state_q     <= state_d;
      mods_q      <= mods_d;
      invs_q      <= invs_d;
      res_q       <= res_d;
      m_q         <= m_d;
      q_tab_q     <= q_tab_d;
      acc_q       <= acc_d;
      idx_i_q     <= idx_i_d;
      idx_j_q     <= idx_j_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_m_q     <= out_m_d;
    end
  end

endmodule

// File: tb/tb_rns2bin_seq_ctrl.sv
// Bench for rns2bin_seq_ctrl with moduli {3,4,5,7} (M = 420).
module tb_rns2bin_seq_ctrl;

  localparam int MOD_NUM = 4;
  localparam int MOD_W   = 4;
  localparam int RANGE   = 16;
  localparam int NVEC    = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [15:0]       cfg_mods;
  logic [15:0]       cfg_invs;
  logic              cfg_done;
  logic              cfg_err;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_res;
  logic              out_valid;
  logic              out_ready;
  logic [RANGE-1:0]  out_x;
  logic [RANGE-1:0]  out_m;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RANGE-1:0] exp_q[$];

  typedef struct {
    logic [15:0] res;
    logic [15:0] exp_x;
  } vec_t;
  vec_t vecs[NVEC];

  rns2bin_seq_ctrl #(.MOD_NUM(MOD_NUM), .MOD_W(MOD_W), .RANGE(RANGE)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mods(cfg_mods), .cfg_invs(cfg_invs),
    .cfg_done(cfg_done), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_m(out_m)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_mods = '0; cfg_invs = '0; in_res = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge, outputs are
  // sampled at the same offset.
  task automatic send_cfg(input logic [15:0] mods, input logic [15:0] invs);
    int w;
    cfg_mods = mods; cfg_invs = invs; cfg_valid = 1'b1;
    w = 0;
    while (!cfg_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_cfg_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!cfg_done && lat < 100);
  endtask

  // Sends one tuple, waits for out_valid, scores out_x. Returns at the
  // sample point of the first out_valid cycle.
  task automatic convert(input logic [15:0] res, input logic [15:0] exp_x,
                         input string name);
    int w;
    int lat;
    logic [RANGE-1:0] e;
    exp_q.push_back(exp_x);
    in_res = res; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 50);
    check({name, "_latency"}, lat, 32'd5);
    e = exp_q.pop_front();
    check({name, "_out_x"}, {16'd0, out_x}, {16'd0, e});
  endtask

  initial begin
    int lat;
    int bad;
    logic saw;
    logic [RANGE-1:0] held;
    logic [RANGE-1:0] exp_qtab[MOD_NUM];

    vecs[0] = '{res: 16'h2001, exp_x: 16'h0064}; // {1,0,0,2} -> +100
    vecs[1] = '{res: 16'h6000, exp_x: 16'hFF88}; // {0,0,0,6} -> -120
    vecs[2] = '{res: 16'h6412, exp_x: 16'h00D1}; // {2,1,4,6} -> +209 max
    vecs[3] = '{res: 16'h0020, exp_x: 16'hFF2E}; // {0,2,0,0} -> -210 min
    vecs[4] = '{res: 16'h0000, exp_x: 16'h0000}; // zero
    vecs[5] = '{res: 16'h6432, exp_x: 16'hFFFF}; // {2,3,4,6} -> -1
    vecs[6] = '{res: 16'h1111, exp_x: 16'h0001}; // {1,1,1,1} -> +1
    vecs[7] = '{res: 16'h0010, exp_x: 16'h0069}; // {0,1,0,0} -> +105
    vecs[8] = '{res: 16'h0004, exp_x: 16'hFF74}; // c0=4 >= 3 acts as 1 -> -140
    exp_qtab[0] = 16'd140; exp_qtab[1] = 16'd105;
    exp_qtab[2] = 16'd84;  exp_qtab[3] = 16'd60;

    do_reset();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_x", {16'd0, out_x}, 32'd0);
    check("rst_out_m", {16'd0, out_m}, 32'd0);
    check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);

    // A tuple before any configuration is never taken
    in_res = 16'h2001; in_valid = 1'b1; saw = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      saw = saw | out_valid | in_ready;
    end
    in_valid = 1'b0;
    check("noconf_ignored", {31'd0, saw}, 32'd0);

    // Modulus of 1 is rejected
    send_cfg(16'h7513, 16'h2412);
    check("badcfg_err", {31'd0, cfg_err}, 32'd1);
    check("badcfg_done", {31'd0, cfg_done}, 32'd0);
    in_valid = 1'b1; saw = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      saw = saw | out_valid | in_ready | cfg_done;
    end
    in_valid = 1'b0;
    check("badcfg_no_accept", {31'd0, saw}, 32'd0);

    // Good configuration {3,4,5,7} / {2,1,4,2}
    send_cfg(16'h7543, 16'h2412);
    check("cfg_err_cleared", {31'd0, cfg_err}, 32'd0);
    wait_cfg_done(lat);
    check("cfg_latency", lat, 32'd20);
    check("cfg_done", {31'd0, cfg_done}, 32'd1);
    check("cfg_out_m", {16'd0, out_m}, 32'd420);
    for (int i = 0; i < MOD_NUM; i++)
      check($sformatf("q_tab_%0d", i), {16'd0, dut.q_tab_q[i]}, {16'd0, exp_qtab[i]});

    // Table-driven conversions with out_ready held high
    for (int v = 0; v < NVEC; v++) convert(vecs[v].res, vecs[v].exp_x, $sformatf("vec%0d", v));
    @(posedge clk); #1;
    check("post_table_idle", {31'd0, out_valid}, 32'd0);

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    convert(16'h0020, 16'hFF2E, "bp");
    held = out_x; bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_x !== held || in_ready !== 1'b0) bad++;
    end
    check("bp_stable_cycles", bad, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    convert(16'h0000, 16'h0000, "bp_next");

    // Reset in the middle of ACC
    @(posedge clk); #1;
    in_res = 16'h6000; in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("midrst_out_m", {16'd0, out_m}, 32'd0);
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      saw = saw | out_valid | in_ready;
    end
    check("midrst_no_stale", {31'd0, saw}, 32'd0);
    send_cfg(16'h7543, 16'h2412);
    wait_cfg_done(lat);
    check("recfg_latency", lat, 32'd20);
    convert(16'h2001, 16'h0064, "after_rst");
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
